// File: rtl/disp_scan_ctrl.sv
// rtl/disp_scan_ctrl.sv - ALU result capture, BCD conversion and 4-digit 7-segment scanner
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   load       one-cycle capture strobe for Sel_op/resultado
//   Sel_op     0 = add, 1 = subtract
//   resultado  [8] carry/sign, [7:0] magnitude bits
//   busy       high while a conversion is in progress
//   sel_disp   digit slot: 00 units, 01 sign, 10 hundreds, 11 tens
//   An         anode enables, active low
//   SSeg       segments gfedcba, active low

module disp_scan_ctrl #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       Sel_op,
    input  logic [8:0] resultado,
    output logic       busy,
    output logic [1:0] sel_disp,
    output logic [3:0] An,
    output logic [6:0] SSeg
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    typedef enum logic {
        ST_IDLE,
        ST_CONV
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic             last_iter;

    logic [3:0]       iter;
    logic             signo;
    logic [8:0]       mag_sr;
    logic [11:0]      shadow;
    logic [11:0]      adj;
    logic [11:0]      shadow_next;

    logic [3:0]       disp_c;
    logic [3:0]       disp_d;
    logic [3:0]       disp_u;
    logic             disp_s;

    logic [CNT_W-1:0] scan_cnt;
    logic [3:0]       digit;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a load is only honoured while idle
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last_iter  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (load) begin
                    accept     = 1'b1;
                    state_next = ST_CONV;
                end
            end
            ST_CONV: begin
                if (iter == 4'd8) begin
                    last_iter  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign busy = (state == ST_CONV);

    // One double-dabble step: add 3 to nibbles >= 5, then shift in the next magnitude bit
    always_comb begin
        adj = shadow;
        if (shadow[3:0] >= 4'd5) begin
            adj[3:0] = shadow[3:0] + 4'd3;
        end
        if (shadow[7:4] >= 4'd5) begin
            adj[7:4] = shadow[7:4] + 4'd3;
        end
        if (shadow[11:8] >= 4'd5) begin
            adj[11:8] = shadow[11:8] + 4'd3;
        end
        shadow_next = {adj[10:0], mag_sr[8]};
    end

    // Conversion datapath; display registers only change on the final iteration
    always_ff @(posedge clk) begin
        if (rst) begin
            iter   <= 4'd0;
            signo  <= 1'b0;
            mag_sr <= 9'd0;
            shadow <= 12'd0;
            disp_c <= 4'd0;
            disp_d <= 4'd0;
            disp_u <= 4'd0;
            disp_s <= 1'b0;
        end else if (accept) begin
            signo  <= Sel_op & resultado[8];
            mag_sr <= (Sel_op & resultado[8]) ? (~resultado + 9'd1) : resultado;
            shadow <= 12'd0;
            iter   <= 4'd0;
        end else if (state == ST_CONV) begin
            shadow <= shadow_next;
            mag_sr <= {mag_sr[7:0], 1'b0};
            iter   <= iter + 4'd1;
            if (last_iter) begin
                disp_c <= shadow_next[11:8];
                disp_d <= shadow_next[7:4];
                disp_u <= shadow_next[3:0];
                disp_s <= signo;
                iter   <= 4'd0;
            end
        end
    end

    // Free-running digit scanner
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt <= '0;
            sel_disp <= 2'b00;
        end else if (scan_cnt == CNT_MAX) begin
            scan_cnt <= '0;
            sel_disp <= sel_disp + 2'b01;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // Sign slot uses code 10 for '-' and 11 for blank
    always_comb begin
        digit = 4'd0;
        case (sel_disp)
            2'b00:   digit = disp_u;
            2'b01:   digit = disp_s ? 4'd10 : 4'd11;
            2'b10:   digit = disp_c;
            default: digit = disp_d;
        endcase
    end

    assign An = ~(4'b0001 << sel_disp);

    always_comb begin
        SSeg = 7'b1111111;
        case (digit)
            4'd0:    SSeg = 7'b1000000;
            4'd1:    SSeg = 7'b1111001;
            4'd2:    SSeg = 7'b0100100;
            4'd3:    SSeg = 7'b0110000;
            4'd4:    SSeg = 7'b0011001;
            4'd5:    SSeg = 7'b0010010;
            4'd6:    SSeg = 7'b0000010;
            4'd7:    SSeg = 7'b1111000;
            4'd8:    SSeg = 7'b0000000;
            4'd9:    SSeg = 7'b0010000;
            4'd10:   SSeg = 7'b0111111;
            default: SSeg = 7'b1111111;
        endcase
    end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// tb/tb_disp_scan_ctrl.sv - self-checking bench for disp_scan_ctrl

module tb_disp_scan_ctrl;

    localparam int DIV = 4;

    logic       clk;
    logic       rst;
    logic       load;
    logic       Sel_op;
    logic [8:0] resultado;
    logic       busy;
    logic [1:0] sel_disp;
    logic [3:0] An;
    logic [6:0] SSeg;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_c, m_d, m_u;
    bit m_s;
    int p_c, p_d, p_u;
    bit p_s;
    int busy_left;
    int ticks;
    logic [6:0] seg_tab [16];

    disp_scan_ctrl #(.REFRESH_DIV(DIV)) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .Sel_op    (Sel_op),
        .resultado (resultado),
        .busy      (busy),
        .sel_disp  (sel_disp),
        .An        (An),
        .SSeg      (SSeg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int s;
        int mag;
        if (rst) begin
            busy_left = 0;
            m_c = 0; m_d = 0; m_u = 0; m_s = 0;
            ticks = 0;
        end else begin
            ticks++;
            if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) begin
                    m_c = p_c; m_d = p_d; m_u = p_u; m_s = p_s;
                end
            end else if (load) begin
                s   = int'(Sel_op) * int'(resultado[8]);
                mag = (s == 1) ? (512 - int'(resultado)) % 512 : int'(resultado);
                p_c = mag / 100;
                p_d = (mag / 10) % 10;
                p_u = mag % 10;
                p_s = (s == 1);
                busy_left = 9;
            end
        end
    endtask

    task automatic tick();
        int sel;
        int dig;
        @(posedge clk);
        model_edge();
        #1;
        sel = (ticks / DIV) % 4;
        if (sel == 0)      dig = m_u;
        else if (sel == 1) dig = m_s ? 10 : 11;
        else if (sel == 2) dig = m_c;
        else               dig = m_d;
        chk("busy", 32'(busy), 32'(busy_left > 0));
        chk("sel_disp", 32'(sel_disp), 32'(sel));
        chk("An", 32'(An), 32'(15 - (1 << sel)));
        chk("SSeg", 32'(SSeg), 32'(seg_tab[dig]));
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) tick();
    endtask

    task automatic do_load(input logic op, input logic [8:0] res);
        Sel_op    = op;
        resultado = res;
        load      = 1'b1;
        tick();
        load      = 1'b0;
    endtask

    initial begin
        seg_tab[0]  = 7'b1000000; seg_tab[1]  = 7'b1111001;
        seg_tab[2]  = 7'b0100100; seg_tab[3]  = 7'b0110000;
        seg_tab[4]  = 7'b0011001; seg_tab[5]  = 7'b0010010;
        seg_tab[6]  = 7'b0000010; seg_tab[7]  = 7'b1111000;
        seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0010000;
        seg_tab[10] = 7'b0111111;
        for (int i = 11; i < 16; i++) seg_tab[i] = 7'b1111111;

        m_c = 0; m_d = 0; m_u = 0; m_s = 0;
        p_c = 0; p_d = 0; p_u = 0; p_s = 0;
        busy_left = 0;
        ticks = 0;

        rst = 1'b1; load = 1'b0; Sel_op = 1'b0; resultado = 9'd0;
        tick();
        tick();
        chk("rst_An", 32'(An), 32'h0000000E);
        chk("rst_SSeg", 32'(SSeg), 32'h00000040);
        chk("rst_busy", 32'(busy), 32'h0);
        rst = 1'b0;

        // Scanner walk over more than one full rotation
        wait_cycles(17);

        // 123 unsigned, then 10 negative
        do_load(1'b0, 9'd123);
        wait_cycles(26);
        do_load(1'b1, 9'h1F6);
        wait_cycles(26);

        // Range boundaries
        do_load(1'b1, 9'h100);
        wait_cycles(26);
        do_load(1'b0, 9'h1FF);
        wait_cycles(26);
        do_load(1'b1, 9'h0FF);
        wait_cycles(26);

        // Loads during busy are dropped, including the one sampled on the commit edge
        do_load(1'b0, 9'd123);
        wait_cycles(3);
        do_load(1'b0, 9'd45);
        wait_cycles(4);
        do_load(1'b0, 9'd77);
        do_load(1'b0, 9'd45);
        wait_cycles(26);

        // Reset in the middle of a conversion
        do_load(1'b0, 9'd123);
        wait_cycles(12);
        do_load(1'b0, 9'd321);
        wait_cycles(4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_sel", 32'(sel_disp), 32'h0);
        wait_cycles(20);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            load      = ($urandom_range(0, 3) == 0);
            rst       = ($urandom_range(0, 149) == 0);
            Sel_op    = 1'($urandom_range(0, 1));
            resultado = 9'($urandom_range(0, 511));
            tick();
        end
        load = 1'b0;
        rst  = 1'b0;
        wait_cycles(12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
